// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 256;
  localparam int OFF_W      = 5;
  localparam int WSEL_W     = 3;
  localparam int LINE_WORDS = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  // Helpers return full-width values; callers size-cast to their field width.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int idx_w);
    return addr >> (OFF_W + idx_w);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int idx_w);
    return (addr >> OFF_W) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return WSEL_W'(addr >> 2);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage for the data cache: combinational read,
// synchronous word and line writes, synchronous clear of valid/dirty.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data
);

  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_line  = data_q[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tags and data carry no reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[index] <= line_data;
      tag_q[index]  <= line_tag;
    end else if (word_we) begin
      data_q[index][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the
// CPU MEM stage and a line-wide multi-cycle data memory.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | serve hits in zero cycles; a miss stalls and picks next state
// WRITEBACK | dirty victim line being written to memory, waiting for ack
// ALLOCATE  | requested line being fetched; on ack it is installed clean
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_index;
  logic [WSEL_W-1:0] cpu_word;
  logic [TAG_W-1:0]  victim_tag;
  logic              line_valid;
  logic              line_dirty;
  logic [LINE_W-1:0] line_data;
  logic [WORD_W-1:0] hit_word;
  logic              hit;
  logic              word_we;
  logic              line_we;
  logic              load_hit;
  logic [WORD_W-1:0] rdata_q;

  assign cpu_tag   = TAG_W'(addr_tag(cpu_addr_i, IDX_W));
  assign cpu_index = IDX_W'(addr_index(cpu_addr_i, IDX_W));
  assign cpu_word  = addr_word(cpu_addr_i);

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .index     (cpu_index),
    .rd_tag    (victim_tag),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_line   (line_data),
    .word_we   (word_we),
    .word_sel  (cpu_word),
    .word_data (cpu_wdata_i),
    .line_we   (line_we),
    .line_tag  (cpu_tag),
    .line_data (mem_rdata_i)
  );

  assign hit         = line_valid && (victim_tag == cpu_tag);
  assign hit_word    = line_data[cpu_word*WORD_W +: WORD_W];
  assign mem_wdata_o = line_data;
  // Load data is live only on a hit; otherwise the last returned word is held.
  assign cpu_rdata_o = load_hit ? hit_word : rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_hit) rdata_q <= hit_word;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {cpu_tag, cpu_index, {OFF_W{1'b0}}};
    word_we     = 1'b0;
    line_we     = 1'b0;
    load_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            word_we  = cpu_we_i;
            load_hit = ~cpu_we_i;
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {victim_tag, cpu_index, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a cache/memory model in plain arrays
// predicts every cycle's outputs; directed scenarios pin the model to literals.
module tb_dcache_ctrl;

  localparam int NL  = 32;
  localparam int IDX = $clog2(NL);
  localparam int TSH = 5 + IDX;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.NUM_LINES(NL)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [255:0] data;
  } xact_t;

  int n_vec = 0;
  int n_err = 0;

  bit           m_valid [NL];
  bit           m_dirty [NL];
  int unsigned  m_tag   [NL];
  logic [255:0] m_line  [NL];
  logic [255:0] mem_line [int unsigned];
  xact_t        txq[$];
  xact_t        obs[$];
  bit           miss_active;
  int           ack_wait;
  int           force_delay = -1;
  bit           force_ack;
  logic [31:0]  last_rdata;

  bit           served;
  logic [31:0]  got_rdata;
  logic         got_stall;
  logic         got_mreq;
  int           dut_stall_cnt;
  int           dut_mreq_cnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mem_get(input logic [31:0] a);
    int unsigned  key;
    logic [255:0] l;
    key = a >> 5;
    if (mem_line.exists(key)) return mem_line[key];
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = (key * 32'h9E37_79B1) ^ (w * 32'h0101_0101) ^ 32'h5A00_0000;
    return l;
  endfunction

  function automatic int pick_delay();
    if (force_delay >= 0) return force_delay;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    txq.delete();
    miss_active = 1'b0;
    last_rdata  = '0;
  endtask

  // One clock cycle: entered just after a falling edge with CPU inputs set.
  task automatic step();
    int unsigned idx, tg, w;
    bit          hit, ack, exp_stall, exp_mreq, chk_rd;
    logic [31:0] exp_rd;
    xact_t       head;
    idx = (cpu_addr_i >> 5) % NL;
    tg  = cpu_addr_i >> TSH;
    w   = (cpu_addr_i >> 2) & 7;
    served = 1'b0; ack = 1'b0; exp_stall = 1'b0; exp_mreq = 1'b0; chk_rd = 1'b0;
    exp_rd = last_rdata;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    head = '{1'b0, 32'h0, 256'h0};
    if (rst_i) begin
      mem_ack_i = 1'b0;
      #1;
      model_reset();
    end else begin
      if (miss_active) begin
        head = txq[0];
        exp_stall = 1'b1; exp_mreq = 1'b1; chk_rd = 1'b1;
        if (ack_wait == 0) ack = 1'b1;
        else ack_wait--;
      end else if (cpu_req_i) begin
        if (hit) begin
          served = 1'b1;
          if (!cpu_we_i) begin
            exp_rd = m_line[idx][w*32 +: 32];
            chk_rd = 1'b1;
          end
        end else begin
          exp_stall = 1'b1;
        end
        ack = force_ack | ($urandom_range(0, 7) == 0);
      end else begin
        ack = force_ack | ($urandom_range(0, 3) == 0);
      end
      mem_ack_i   = ack;
      mem_rdata_i = (miss_active && !head.we) ? mem_get(head.addr)
                                              : {$urandom, $urandom, $urandom, $urandom,
                                                 $urandom, $urandom, $urandom, $urandom};
      #1;
      chk("cpu_stall", cpu_stall_o, exp_stall);
      chk("mem_req", mem_req_o, exp_mreq);
      if (chk_rd) chk("cpu_rdata", cpu_rdata_o, exp_rd);
      if (exp_mreq) begin
        chk("mem_we", mem_we_o, head.we);
        chk("mem_addr", mem_addr_o, head.addr);
        if (head.we) chk("mem_wdata", mem_wdata_o, head.data);
      end
      got_rdata = cpu_rdata_o;
      got_stall = cpu_stall_o;
      got_mreq  = mem_req_o;
      if (cpu_stall_o === 1'b1) dut_stall_cnt++;
      if (mem_req_o === 1'b1) dut_mreq_cnt++;
      if (exp_mreq && ack) obs.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
      if (miss_active) begin
        if (ack) begin
          if (head.we) mem_line[head.addr >> 5] = head.data;
          else begin
            m_line[idx]  = mem_get(head.addr);
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
          end
          void'(txq.pop_front());
          if (txq.size() == 0) miss_active = 1'b0;
          else ack_wait = pick_delay();
        end
      end else if (cpu_req_i) begin
        if (hit) begin
          if (cpu_we_i) begin
            m_line[idx][w*32 +: 32] = cpu_wdata_i;
            m_dirty[idx] = 1'b1;
          end else begin
            last_rdata = exp_rd;
          end
        end else begin
          if (m_valid[idx] && m_dirty[idx])
            txq.push_back('{1'b1, (m_tag[idx] << TSH) | (idx << 5), m_line[idx]});
          txq.push_back('{1'b0, cpu_addr_i & ~32'h1F, 256'h0});
          miss_active = 1'b1;
          ack_wait    = pick_delay();
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
    for (int n = 0; n < 40; n++) begin
      step();
      if (served) break;
    end
    if (!served) begin
      n_vec++; n_err++;
      $display("FAIL access_timeout: addr %h not served within 40 cycles", a);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0, r0;
    int          n0;
    logic [255:0] l;
    logic [31:0] a;
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0; force_ack = 1'b0;
    dut_stall_cnt = 0; dut_mreq_cnt = 0;
    @(negedge clk_i);
    step();
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);
    rst_i = 1'b0;

    l = mem_get(32'h40);
    l[95:64] = 32'hDEAD_BEEF;
    mem_line[32'h40 >> 5] = l;

    force_delay = 3;
    access(1'b0, 32'h48, 32'h0);
    force_delay = -1;
    chk("tp_fill_we", obs[0].we, 1'b0);
    chk("tp_fill_addr", obs[0].addr, 32'h40);
    chk("tp_fill_word", got_rdata, 32'hDEAD_BEEF);

    s0 = dut_stall_cnt; r0 = dut_mreq_cnt;
    access(1'b1, 32'h44, 32'h1234_5678);
    access(1'b0, 32'h44, 32'h0);
    chk("tp_store_load", got_rdata, 32'h1234_5678);
    chk("tp_store_no_stall", dut_stall_cnt - s0, 0);
    chk("tp_store_no_mem", dut_mreq_cnt - r0, 0);

    n0 = obs.size();
    access(1'b0, 32'h440, 32'h0);
    chk("tp_wb_we", obs[n0].we, 1'b1);
    chk("tp_wb_addr", obs[n0].addr, 32'h40);
    chk("tp_wb_word1", obs[n0].data[63:32], 32'h1234_5678);
    chk("tp_alloc_addr", obs[n0+1].addr, 32'h440);

    s0 = dut_stall_cnt; r0 = dut_mreq_cnt;
    for (int i = 0; i < 8; i++) access(1'b0, 32'h440 + 32'(i * 4), 32'h0);
    chk("burst_no_stall", dut_stall_cnt - s0, 0);
    chk("burst_no_mem", dut_mreq_cnt - r0, 0);

    cpu_req_i = 1'b0; force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    s0 = dut_stall_cnt;
    access(1'b0, 32'h444, 32'h0);
    chk("spurious_ack_still_hit", dut_stall_cnt - s0, 0);

    access(1'b1, 32'h448, 32'hA5A5_5A5A);
    access(1'b0, 32'h448, 32'h0);
    chk("store_then_load", got_rdata, 32'hA5A5_5A5A);

    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h800; force_delay = 5;
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; force_delay = -1;
    step();
    chk("rst_abort_req", got_mreq, 1'b0);
    chk("rst_reload_miss", got_stall, 1'b1);
    access(1'b0, 32'h800, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        cpu_req_i = 1'b0;
        step();
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FC00 : 32'($urandom_range(0, 3)) << TSH;
        a = a | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
        access(1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
